ifft8_seq: RTL and testbench

//  Inverse 8-point radix-2 DIT transform: the receive-side counterpart of fft8, converting frequency bins back to time samples.

---
 rtl/ifft8_seq.sv | 195 +++++++++++++++++++
 tb/tb_ifft8_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft8_seq.sv
// Purpose: sequential 8-point inverse FFT (radix-2 DIT, 1/8 scaled) with one shared butterfly.
// Latency: 8 load beats, 12 compute cycles, 8 unload beats; first sample handshakes 13 cycles after Y7.
// Backpressure: in_ready only in LOAD; out_ready low freezes the current sample and the unload index.
module ifft8_seq #(
    parameter int DW = 24,
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_real,
    output logic [DW-1:0] out_imag,
    output logic          out_last,
    output logic          busy
);

    localparam int FR = 13;
    localparam int PW = DW + TW + 1;

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_UNLOAD  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [2:0] ld_cnt;
    logic [3:0] bf_cnt;
    logic [2:0] ul_cnt;

    logic signed [DW-1:0] rf_re [0:7];
    logic signed [DW-1:0] rf_im [0:7];

    logic in_hs, out_hs;

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    // Clamp a DW+3 bit result into DW bits; the top four bits must agree to fit.
    function automatic logic [DW-1:0] sat(input logic [DW+2:0] v);
        if (v[DW+2:DW-1] == '0 || v[DW+2:DW-1] == '1)
            return v[DW-1:0];
        else if (v[DW+2])
            return {1'b1, {(DW-1){1'b0}}};
        else
            return {1'b0, {(DW-1){1'b1}}};
    endfunction

    assign in_hs  = in_valid && (state_q == S_LOAD);
    assign out_hs = out_ready && (state_q == S_UNLOAD);

    // Butterfly addressing: stage in bf_cnt[3:2], unit in bf_cnt[1:0].
    logic [2:0] p, q;
    logic [1:0] w;
    logic [1:0] k;
    assign k = bf_cnt[1:0];

    always_comb begin
        p = '0;
        q = '0;
        w = '0;
        case (bf_cnt[3:2])
            2'd0: begin
                p = {k, 1'b0};
                q = {k, 1'b1};
                w = 2'd0;
            end
            2'd1: begin
                p = {k[1], 1'b0, k[0]};
                q = {k[1], 1'b1, k[0]};
                w = {k[0], 1'b0};
            end
            default: begin
                p = {1'b0, k};
                q = {1'b1, k};
                w = k;
            end
        endcase
    end

    // Conjugate twiddles W8^-w, Q2.13.
    logic signed [TW-1:0] wr, wi;
    always_comb begin
        wr = '0;
        wi = '0;
        case (w)
            2'd0: begin wr = TW'(16'sh2000); wi = TW'(16'sh0000); end
            2'd1: begin wr = TW'(16'sh16A0); wi = TW'(16'sh16A0); end
            2'd2: begin wr = TW'(16'sh0000); wi = TW'(16'sh2000); end
            default: begin wr = TW'(16'shE960); wi = TW'(16'sh16A0); end
        endcase
    end

    logic signed [DW-1:0] ar, ai, br, bi;
    logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x;
    logic signed [PW-1:0] prod_re, prod_im;
    logic signed [DW+2:0] t_re, t_im;
    logic signed [DW+3:0] s_re, s_im, d_re, d_im;
    logic [DW+2:0]        sh_s_re, sh_s_im, sh_d_re, sh_d_im;

    assign ar = rf_re[p];
    assign ai = rf_im[p];
    assign br = rf_re[q];
    assign bi = rf_im[q];

    assign br_x = {{(TW+1){br[DW-1]}}, br};
    assign bi_x = {{(TW+1){bi[DW-1]}}, bi};
    assign wr_x = {{(DW+1){wr[TW-1]}}, wr};
    assign wi_x = {{(DW+1){wi[TW-1]}}, wi};

    assign prod_re = br_x * wr_x - bi_x * wi_x;
    assign prod_im = br_x * wi_x + bi_x * wr_x;

    // Round half-up at bit 13; magnitude stays below 2^25 so DW+3 bits cannot wrap.
    assign t_re = (DW+3)'((prod_re + PW'(4096)) >>> FR);
    assign t_im = (DW+3)'((prod_im + PW'(4096)) >>> FR);

    assign s_re = {{4{ar[DW-1]}}, ar} + {t_re[DW+2], t_re};
    assign s_im = {{4{ai[DW-1]}}, ai} + {t_im[DW+2], t_im};
    assign d_re = {{4{ar[DW-1]}}, ar} - {t_re[DW+2], t_re};
    assign d_im = {{4{ai[DW-1]}}, ai} - {t_im[DW+2], t_im};

    assign sh_s_re = (DW+3)'(s_re >>> 1);
    assign sh_s_im = (DW+3)'(s_im >>> 1);
    assign sh_d_re = (DW+3)'(d_re >>> 1);
    assign sh_d_im = (DW+3)'(d_im >>> 1);

    always_ff @(posedge clk) begin
        if (in_hs) begin
            rf_re[bitrev3(ld_cnt)] <= in_real;
            rf_im[bitrev3(ld_cnt)] <= in_imag;
        end else if (state_q == S_COMPUTE) begin
            rf_re[p] <= sat(sh_s_re);
            rf_im[p] <= sat(sh_s_im);
            rf_re[q] <= sat(sh_d_re);
            rf_im[q] <= sat(sh_d_im);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            ld_cnt  <= '0;
            bf_cnt  <= '0;
            ul_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (in_hs)
                ld_cnt <= ld_cnt + 3'd1;
            if (state_q == S_COMPUTE)
                bf_cnt <= (bf_cnt == 4'd11) ? 4'd0 : bf_cnt + 4'd1;
            if (out_hs)
                ul_cnt <= ul_cnt + 3'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_real  = '0;
        out_imag  = '0;
        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_hs && ld_cnt == 3'd7)
                    state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (bf_cnt == 4'd11)
                    state_d = S_UNLOAD;
            end
            S_UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (ul_cnt == 3'd7);
                out_real  = rf_re[ul_cnt];
                out_imag  = rf_im[ul_cnt];
                if (out_hs && ul_cnt == 3'd7)
                    state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

endmodule

// File: tb/tb_ifft8_seq.sv
// Directed table vectors plus model-checked saturation/random frames, backpressure and mid-frame reset.
module tb_ifft8_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_real, in_imag;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_real, out_imag;
    logic        out_last;
    logic        busy;

    always #5 clk = ~clk;

    ifft8_seq #(.DW(24), .TW(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
        .out_last(out_last), .busy(busy)
    );

    typedef logic [7:0][23:0] frame_t;
    typedef struct {
        frame_t yr, yi, xr, xi;
        int     tol;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    int tone_r[8] = '{1024, 724, 0, -724, -1024, -724, 0, 724};
    int tone_i[8] = '{0, 724, 1024, 724, 0, -724, -1024, -724};
    int alt_r[8]  = '{256, 0, -256, 0, 256, 0, -256, 0};
    int alt_i[8]  = '{0, 256, 0, -256, 0, 256, 0, -256};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp, input int tol);
        n_checks++;
        if (act - exp > tol || exp - act > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    function automatic longint sx(input logic [23:0] v);
        return longint'($signed(v));
    endfunction

    // Reference inverse transform written straight from the algorithm description.
    function automatic void ref_ifft(input frame_t yr, input frame_t yi, output frame_t xr, output frame_t xi);
        longint rr[8], ri[8];
        longint twr[4] = '{8192, 5792, 0, -5792};
        longint twi[4] = '{0, 5792, 8192, 5792};
        for (int n = 0; n < 8; n++) begin
            int b;
            b = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
            rr[b] = sx(yr[n]);
            ri[b] = sx(yi[n]);
        end
        for (int s = 0; s < 3; s++) begin
            for (int kk = 0; kk < 4; kk++) begin
                int half, j, pp, qq, ww;
                longint tr, ti, a_r, a_i, v[4];
                half = 1 << s;
                j    = kk & (half - 1);
                pp   = ((kk >> s) << (s + 1)) + j;
                qq   = pp + half;
                ww   = j << (2 - s);
                tr   = (rr[qq] * twr[ww] - ri[qq] * twi[ww] + 4096) >>> 13;
                ti   = (rr[qq] * twi[ww] + ri[qq] * twr[ww] + 4096) >>> 13;
                a_r  = rr[pp];
                a_i  = ri[pp];
                v[0] = (a_r + tr) >>> 1;
                v[1] = (a_i + ti) >>> 1;
                v[2] = (a_r - tr) >>> 1;
                v[3] = (a_i - ti) >>> 1;
                for (int e = 0; e < 4; e++) begin
                    if (v[e] > 8388607) v[e] = 8388607;
                    if (v[e] < -8388608) v[e] = -8388608;
                end
                rr[pp] = v[0]; ri[pp] = v[1];
                rr[qq] = v[2]; ri[qq] = v[3];
            end
        end
        for (int n = 0; n < 8; n++) begin
            xr[n] = 24'(rr[n]);
            xi[n] = 24'(ri[n]);
        end
    endfunction

    task automatic send_frame(input frame_t yr, input frame_t yi, input bit gaps);
        for (int n = 0; n < 8; n++) begin
            int w;
            if (gaps && (n % 2 == 1)) begin
                in_valid = 1'b0;
                in_real  = 24'hDEAD00;
                in_imag  = 24'h00BEEF;
                step();
            end
            in_valid = 1'b1;
            in_real  = yr[n];
            in_imag  = yi[n];
            w = 0;
            while (!in_ready && w < 100) begin
                step();
                w++;
            end
            if (w >= 100) begin
                check("in_ready timeout", 0, 1, 0);
                in_valid = 1'b0;
                return;
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic recv_frame(output frame_t xr, output frame_t xi, output int lat, input int stall_at);
        bit ir_ok = 1'b1;
        xr  = '0;
        xi  = '0;
        lat = -1;
        out_ready = 1'b1;
        for (int m = 0; m < 8; m++) begin
            int w = 0;
            while (!out_valid && w < 200) begin
                if (in_ready) ir_ok = 1'b0;
                step();
                w++;
            end
            if (w >= 200) begin
                check("out_valid timeout", 0, 1, 0);
                return;
            end
            if (m == 0) lat = w;
            if (in_ready) ir_ok = 1'b0;
            check($sformatf("out_last beat %0d", m), longint'(out_last), (m == 7) ? 1 : 0, 0);
            if (m == stall_at) begin
                logic [23:0] hr, hi;
                bit hold_ok = 1'b1;
                out_ready = 1'b0;
                hr = out_real;
                hi = out_imag;
                repeat (3) begin
                    step();
                    if (!out_valid || out_real != hr || out_imag != hi || out_last || in_ready)
                        hold_ok = 1'b0;
                end
                check("stall hold beat", longint'(hold_ok), 1, 0);
                out_ready = 1'b1;
            end
            xr[m] = out_real;
            xi[m] = out_imag;
            step();
        end
        check("in_ready low while busy", longint'(ir_ok), 1, 0);
        check("in_ready after x7", longint'(in_ready), 1, 0);
        check("out_valid after x7", longint'(out_valid), 0, 0);
        check("busy after x7", longint'(busy), 0, 0);
    endtask

    task automatic cmp_frame(input string name, input frame_t xr, input frame_t xi,
                             input frame_t er, input frame_t ei, input int tol);
        for (int n = 0; n < 8; n++) begin
            check($sformatf("%s x%0d re", name, n), sx(xr[n]), sx(er[n]), tol);
            check($sformatf("%s x%0d im", name, n), sx(xi[n]), sx(ei[n]), tol);
        end
    endtask

    task automatic pulse_reset(input string name);
        bit quiet = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check({name, " in_ready"}, longint'(in_ready), 1, 0);
        check({name, " out_valid"}, longint'(out_valid), 0, 0);
        check({name, " busy"}, longint'(busy), 0, 0);
        repeat (20) begin
            step();
            if (out_valid || busy) quiet = 1'b0;
        end
        check({name, " no partial output"}, longint'(quiet), 1, 0);
    endtask

    initial begin
        vec_t   vecs[4];
        frame_t imp_r, imp_i, zr, zi, gr, gi, er, ei, yr, yi;
        int     lat;

        // Impulse, single tone, negative complex DC, and Y2 tone.
        zr = '0; zi = '0;
        for (int v = 0; v < 4; v++) begin
            vecs[v].yr = '0; vecs[v].yi = '0; vecs[v].tol = 0;
        end
        vecs[0].yr[0] = 24'h000800;
        vecs[1].yr[1] = 24'h002000;
        vecs[1].tol   = 1;
        vecs[2].yr[0] = -24'sd2048;
        vecs[2].yi[0] = 24'd4096;
        vecs[3].yr[2] = 24'h000800;
        for (int n = 0; n < 8; n++) begin
            vecs[0].xr[n] = 24'h000100;  vecs[0].xi[n] = '0;
            vecs[1].xr[n] = 24'(tone_r[n]); vecs[1].xi[n] = 24'(tone_i[n]);
            vecs[2].xr[n] = -24'sd256;   vecs[2].xi[n] = 24'd512;
            vecs[3].xr[n] = 24'(alt_r[n]); vecs[3].xi[n] = 24'(alt_i[n]);
        end
        imp_r = vecs[0].yr; imp_i = vecs[0].yi;

        rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0; out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check("reset in_ready", longint'(in_ready), 1, 0);
        check("reset out_valid", longint'(out_valid), 0, 0);
        check("reset out_last", longint'(out_last), 0, 0);
        check("reset busy", longint'(busy), 0, 0);
        check("reset out_real", sx(out_real), 0, 0);
        check("reset out_imag", sx(out_imag), 0, 0);

        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].yr, vecs[v].yi, 1'b0);
            recv_frame(gr, gi, lat, -1);
            if (v == 0) check("Y7 accept to first out handshake minus 1", lat, 12, 0);
            cmp_frame($sformatf("vec%0d", v), gr, gi, vecs[v].xr, vecs[v].xi, vecs[v].tol);
        end

        // Full-scale frames: all positive max, and alternating-sign full scale.
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 8; n++) begin
                case (f)
                    0: begin yr[n] = 24'h7FFFFF; yi[n] = 24'h7FFFFF; end
                    1: begin yr[n] = (n % 2 == 0) ? 24'h7FFFFF : 24'h800000;
                             yi[n] = (n % 2 == 0) ? 24'h800000 : 24'h7FFFFF; end
                    default: begin yr[n] = (n < 4) ? 24'h7FFFFF : 24'h800000;
                                   yi[n] = (n % 3 == 0) ? 24'h800000 : 24'h7FFFFF; end
                endcase
            end
            ref_ifft(yr, yi, er, ei);
            send_frame(yr, yi, 1'b0);
            recv_frame(gr, gi, lat, -1);
            cmp_frame($sformatf("sat%0d", f), gr, gi, er, ei, 0);
        end

        for (int f = 0; f < 4; f++) begin
            for (int n = 0; n < 8; n++) begin
                yr[n] = 24'($urandom);
                yi[n] = 24'($urandom);
            end
            ref_ifft(yr, yi, er, ei);
            send_frame(yr, yi, 1'b0);
            recv_frame(gr, gi, lat, -1);
            cmp_frame($sformatf("rand%0d", f), gr, gi, er, ei, 0);
        end

        // Input gaps plus a 3-cycle stall at beat 4.
        send_frame(imp_r, imp_i, 1'b1);
        recv_frame(gr, gi, lat, 4);
        cmp_frame("backpressure", gr, gi, vecs[0].xr, vecs[0].xi, 0);

        // Reset during COMPUTE.
        send_frame(vecs[1].yr, vecs[1].yi, 1'b0);
        repeat (5) step();
        check("mid-compute busy before reset", longint'(busy), 1, 0);
        pulse_reset("rst mid-compute");
        send_frame(imp_r, imp_i, 1'b0);
        recv_frame(gr, gi, lat, -1);
        cmp_frame("after rst compute", gr, gi, vecs[0].xr, vecs[0].xi, 0);

        // Reset during UNLOAD after three delivered beats.
        send_frame(vecs[1].yr, vecs[1].yi, 1'b0);
        out_ready = 1'b1;
        for (int m = 0; m < 3; m++) begin
            int w = 0;
            while (!out_valid && w < 200) begin
                step();
                w++;
            end
            step();
        end
        check("mid-unload out_valid before reset", longint'(out_valid), 1, 0);
        pulse_reset("rst mid-unload");
        send_frame(imp_r, imp_i, 1'b0);
        recv_frame(gr, gi, lat, -1);
        cmp_frame("after rst unload", gr, gi, vecs[0].xr, vecs[0].xi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
